flagi: RTL and testbench
========================

Name: flagi

Overview:
- Processor status-flag register holding Carry (C), Overflow (OV), Parity (P), Zero (Z) and Sign (S).
- Sits between the ALU flag outputs and the control unit / conditional-branch logic.
- P, Z and S reload every cycle from the ALU.
- C and OV reload only when the datapath asserts C_OV_en, so they survive non-arithmetic instructions.

Parameters:
- RST_FLAGS, 5'b00000, reset value of the flag vector, ordered {S,Z,P,OV,C}; bit i applies to the matching flag.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- C_OV_en  input  1  load enable for C and OV
- C_in  input  1  next carry from ALU
- OV_in  input  1  next overflow from ALU
- P_in  input  1  next parity from ALU
- Z_in  input  1  next zero from ALU
- S_in  input  1  next sign from ALU
- C_out  output  1  registered carry flag
- OV_out  output  1  registered overflow flag
- P_out  output  1  registered parity flag
- Z_out  output  1  registered zero flag
- S_out  output  1  registered sign flag

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on a rising edge with rst=1, each output takes its RST_FLAGS bit (default all 0). Reset overrides C_OV_en and all *_in.
- P, Z, S: on every rising edge with rst=0, X_out <= X_in. No enable.
- C, OV: on a rising edge with rst=0 and C_OV_en=1, C_out <= C_in and OV_out <= OV_in. With C_OV_en=0 both hold their value, whatever C_in/OV_in do.
- Latency:
  - Outputs change exactly one rising edge after the inputs are sampled.
  - Outputs are purely registered; there is no combinational path from any input to any output.
- C and OV always load together; there is no individual enable.
- Outputs are stable between edges. Input glitches between edges have no effect.
- Reset mid-operation: the edge with rst=1 clears the flags regardless of pending enable. The first edge after rst drops loads normally.
- No X propagation: all five flops are reset. Outputs are X only before the first reset edge.

Optional Feature:
- Macro: FLAGI_PACKED_OUT_EN
- When defined:
  - Adds output flags_word[4:0] = {S_out,Z_out,P_out,OV_out,C_out}, driven directly from the flag flops with no extra latency.
  - Adds input flags_restore_en (1 bit) and input flags_restore[4:0].
  - When flags_restore_en=1 and rst=0, all five flags load from flags_restore on the edge. This takes priority over the normal C_OV_en and *_in updates. It is used for interrupt return.
- When undefined: these ports do not exist; behaviour is exactly as above.

Decomposition:
- Package flagi_pkg:
  - localparam bit indices FLAG_C=0, FLAG_OV=1, FLAG_P=2, FLAG_Z=3, FLAG_S=4.
  - FLAG_W=5.
  - typedef flags_t as a packed struct {S,Z,P,OV,C}.
- Sub-module flag_bit: one flop with sync reset, reset value parameter and load enable. Instantiate five times:
  - P, Z and S have enable tied high.
  - C and OV share C_OV_en.

Test Plan:
- Reset: drive all *_in=1, C_OV_en=1, rst=1 for 2 edges -> all outputs 0 (default RST_FLAGS). Release rst -> next edge all outputs 1.
- Always-load flags: rst=0, drive P_in=1, then Z_in=1, then Z_in=0, then P_in=0, then S_in=1, then S_in=0, one change per cycle -> each P_out/Z_out/S_out follows its input one edge later. C_out stays 0.
- Carry gating: C_OV_en=0, C_in=1 for one cycle -> C_out stays 0. Then C_OV_en=1, C_in=1 -> C_out=1 after the edge. Then C_OV_en=0, C_in=0 -> C_out holds 1.
- Overflow gating: C_OV_en=1, OV_in=1 -> OV_out=1 next edge. Then C_OV_en=0, OV_in=0 for 3 cycles -> OV_out stays 1.
- Reset priority: flags all 1, assert rst with C_OV_en=1 and all *_in=1 for one edge -> all outputs 0. Next edge with rst=0 -> all outputs 1.
- With FLAGI_PACKED_OUT_EN: flags_restore=5'b10101, flags_restore_en=1, all *_in=0 -> flags_word=5'b10101, i.e. S=1, P=1, C=1 after one edge.

Source files
------------

// File: rtl/flagi_pkg.sv
// Shared definitions for the flagi status-flag register: bit positions and the flag vector layout.
package flagi_pkg;
  localparam int FLAG_C  = 0;
  localparam int FLAG_OV = 1;
  localparam int FLAG_P  = 2;
  localparam int FLAG_Z  = 3;
  localparam int FLAG_S  = 4;
  localparam int FLAG_W  = 5;

  typedef struct packed {
    logic s;
    logic z;
    logic p;
    logic ov;
    logic c;
  } flags_t;
endpackage

// File: rtl/flagi_flag_bit.sv
// Single status-flag flop: synchronous active-high reset to RST_VAL and a load enable.
module flag_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/flagi.sv
// Processor status-flag register {S,Z,P,OV,C}; P/Z/S load every cycle, C/OV only on C_OV_en.
// Optional macro FLAGI_PACKED_OUT_EN adds a packed flag output and a whole-vector restore path.
module flagi
  import flagi_pkg::*;
#(
  parameter logic [FLAG_W-1:0] RST_FLAGS = 5'b00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              C_OV_en,
  input  logic              C_in,
  input  logic              OV_in,
  input  logic              P_in,
  input  logic              Z_in,
  input  logic              S_in,
`ifdef FLAGI_PACKED_OUT_EN
  input  logic              flags_restore_en,
  input  logic [FLAG_W-1:0] flags_restore,
  output logic [FLAG_W-1:0] flags_word,
`endif
  output logic              C_out,
  output logic              OV_out,
  output logic              P_out,
  output logic              Z_out,
  output logic              S_out
);
  flags_t            nxt;
  logic [FLAG_W-1:0] nxt_vec;
  logic [FLAG_W-1:0] en_vec;
  logic [FLAG_W-1:0] q_vec;

  always_comb begin
    nxt             = '{s: S_in, z: Z_in, p: P_in, ov: OV_in, c: C_in};
    nxt_vec         = nxt;
    en_vec          = '1;
    en_vec[FLAG_C]  = C_OV_en;
    en_vec[FLAG_OV] = C_OV_en;
`ifdef FLAGI_PACKED_OUT_EN
    // Interrupt return reloads every flag and overrides the ALU path.
    if (flags_restore_en) begin
      nxt_vec = flags_restore;
      en_vec  = '1;
    end
`endif
  end

  for (genvar i = 0; i < FLAG_W; i++) begin : g_flag
    flag_bit #(.RST_VAL(RST_FLAGS[i])) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en_vec[i]),
      .d   (nxt_vec[i]),
      .q   (q_vec[i])
    );
  end

  assign C_out  = q_vec[FLAG_C];
  assign OV_out = q_vec[FLAG_OV];
  assign P_out  = q_vec[FLAG_P];
  assign Z_out  = q_vec[FLAG_Z];
  assign S_out  = q_vec[FLAG_S];
`ifdef FLAGI_PACKED_OUT_EN
  assign flags_word = q_vec;
`endif
endmodule

// File: tb/tb_flagi.sv
// Self-checking bench for flagi: per-flag expected state model plus literal anchor checks.
module tb_flagi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic C_OV_en = 1'b0;
  logic C_in = 1'b0, OV_in = 1'b0, P_in = 1'b0, Z_in = 1'b0, S_in = 1'b0;
  logic C_out, OV_out, P_out, Z_out, S_out;
`ifdef FLAGI_PACKED_OUT_EN
  logic       flags_restore_en = 1'b0;
  logic [4:0] flags_restore = 5'b0;
  logic [4:0] flags_word;
`endif

  int checks = 0;
  int errors = 0;

  // Expected flag values, one variable per flag.
  logic e_c, e_ov, e_p, e_z, e_s;
  bit   model_valid = 1'b0;

  always #5 clk = ~clk;

  flagi dut (
    .clk     (clk),
    .rst     (rst),
    .C_OV_en (C_OV_en),
    .C_in    (C_in),
    .OV_in   (OV_in),
    .P_in    (P_in),
    .Z_in    (Z_in),
    .S_in    (S_in),
`ifdef FLAGI_PACKED_OUT_EN
    .flags_restore_en (flags_restore_en),
    .flags_restore    (flags_restore),
    .flags_word       (flags_word),
`endif
    .C_out   (C_out),
    .OV_out  (OV_out),
    .P_out   (P_out),
    .Z_out   (Z_out),
    .S_out   (S_out)
  );

  function automatic logic [4:0] dut_vec();
    return {S_out, Z_out, P_out, OV_out, C_out};
  endfunction

  // Compare against the model on every falling edge once the model is defined.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (dut_vec() !== {e_s, e_z, e_p, e_ov, e_c}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, dut_vec(),
                 {e_s, e_z, e_p, e_ov, e_c});
      end
`ifdef FLAGI_PACKED_OUT_EN
      checks++;
      if (flags_word !== {e_s, e_z, e_p, e_ov, e_c}) begin
        errors++;
        $display("FAIL flags_word_cmp t=%0t got=%b exp=%b", $time, flags_word,
                 {e_s, e_z, e_p, e_ov, e_c});
      end
`endif
    end
  end

  // One clock: drive inputs at negedge, advance model on the edge. in_v = {S,Z,P,OV,C}.
  task automatic step(input logic r, input logic en, input logic [4:0] in_v,
                      input logic rs_en, input logic [4:0] rs_v);
    @(negedge clk);
    #1;
    rst = r; C_OV_en = en;
    {S_in, Z_in, P_in, OV_in, C_in} = in_v;
`ifdef FLAGI_PACKED_OUT_EN
    flags_restore_en = rs_en; flags_restore = rs_v;
`endif
    @(posedge clk);
    if (r) begin
      {e_s, e_z, e_p, e_ov, e_c} = 5'b00000;
      model_valid = 1'b1;
`ifdef FLAGI_PACKED_OUT_EN
    end else if (rs_en) begin
      {e_s, e_z, e_p, e_ov, e_c} = rs_v;
`endif
    end else begin
      e_s = in_v[4]; e_z = in_v[3]; e_p = in_v[2];
      if (en) begin
        e_ov = in_v[1]; e_c = in_v[0];
      end
    end
    #1;
  endtask

  task automatic go(input logic r, input logic en, input logic [4:0] in_v);
    step(r, en, in_v, 1'b0, 5'b0);
  endtask

  task automatic lit(input string name, input logic [4:0] exp);
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, dut_vec(), exp);
    end
  endtask

  initial begin
    // Reset held two edges with every input high.
    go(1, 1, 5'b11111);
    go(1, 1, 5'b11111);
    lit("reset_all_zero", 5'b00000);
    go(0, 1, 5'b11111);
    lit("release_all_one", 5'b11111);

    // Clear, then walk P/Z/S one change per cycle with C/OV disabled.
    go(1, 0, 5'b00000);
    lit("reset_clear", 5'b00000);
    go(0, 0, 5'b00100);  // P=1
    lit("p_set", 5'b00100);
    go(0, 0, 5'b01100);  // Z=1
    go(0, 0, 5'b00100);  // Z=0
    go(0, 0, 5'b00000);  // P=0
    go(0, 0, 5'b10000);  // S=1
    lit("s_set_c_zero", 5'b10000);
    go(0, 0, 5'b00000);  // S=0

    // Carry gating.
    go(0, 0, 5'b00001);
    lit("c_blocked", 5'b00000);
    go(0, 1, 5'b00001);
    lit("c_loaded", 5'b00001);
    go(0, 0, 5'b00000);
    lit("c_held", 5'b00001);

    // Overflow gating, held for three cycles.
    go(0, 1, 5'b00011);
    lit("ov_loaded", 5'b00011);
    for (int i = 0; i < 3; i++) go(0, 0, 5'b00000);
    lit("ov_held", 5'b00011);

    // Inputs toggling under C_OV_en=0 must not move C/OV.
    go(0, 0, 5'b01000);
    go(0, 0, 5'b10110);
    lit("mix_hold", 5'b10111);
    go(0, 1, 5'b01010);
    lit("mix_load", 5'b01010);

    // Reset priority over pending enable.
    go(0, 1, 5'b11111);
    lit("pre_rst_ones", 5'b11111);
    go(1, 1, 5'b11111);
    lit("rst_priority", 5'b00000);
    go(0, 1, 5'b11111);
    lit("post_rst_ones", 5'b11111);

`ifdef FLAGI_PACKED_OUT_EN
    step(0, 1, 5'b00000, 1'b1, 5'b10101);
    lit("restore_10101", 5'b10101);
    checks++;
    if (flags_word !== 5'b10101) begin
      errors++;
      $display("FAIL restore_word got=%b exp=%b", flags_word, 5'b10101);
    end
    step(1, 1, 5'b11111, 1'b1, 5'b11111);
    lit("restore_vs_rst", 5'b00000);
    go(0, 0, 5'b00100);
    lit("after_restore_norm", 5'b00100);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
